// File: rtl/key_debouncer.sv
// Pushbutton conditioner: synchronises the raw active-low key, debounces it and
// derives press/release strobes plus a press-toggled blink enable.
`timescale 1ns/1ps
module key_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic system1000,
  input  logic system1000_rstn,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic blink_en
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   en_q, en_d;
  logic                   sync_key;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], key_n};
    sync_key  = ~sync_q[SYNC_STAGES-1];
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    en_d      = en_q;
    // Any sample agreeing with the stable level leaves cnt_d at 0, restarting the count.
    if (sync_key != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d   = sync_key;
        press_d   = sync_key;
        release_d = ~sync_key;
        en_d      = en_q ^ sync_key;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      en_q      <= en_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign blink_en    = en_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed vector table, a reset-mid-debounce sequence,
// and randomized key traffic checked against behavioural models of two configurations.
`timescale 1ns/1ps
module tb_key_debouncer;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic key_n = 1'b1;
  logic level0, press0, rel0, en0;
  logic level1, press1, rel1, en1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_debouncer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .system1000(clk), .system1000_rstn(rstn), .key_n(key_n),
    .key_level(level0), .key_press(press0), .key_release(rel0), .blink_en(en0)
  );

  key_debouncer #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(1)) dut1 (
    .system1000(clk), .system1000_rstn(rstn), .key_n(key_n),
    .key_level(level1), .key_press(press1), .key_release(rel1), .blink_en(en1)
  );

  // Main model: raw key sample stream delayed by S edges, flip once the last D
  // samples since the previous flip all disagree with the current level.
  bit m_pipe[$];
  bit m_hist[$];
  bit m_level, m_press, m_rel, m_en;

  // Single-cycle-debounce model: level is the inverted key from S1 edges ago,
  // provided no reset occurred within that window.
  bit h_r[$];
  bit h_k[$];
  bit n_level, n_press, n_rel, n_en, n_prev;
  bit n_on = 1'b0;

  function automatic bit hist_r(int back);
    if (back < h_r.size()) return h_r[h_r.size()-1-back];
    return 1'b0;
  endfunction

  function automatic bit hist_k(int back);
    if (back < h_k.size()) return h_k[h_k.size()-1-back];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (level,press,release,en)", name, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic k);
    bit sk, flip, ok;
    if (!r) begin
      m_pipe.delete();
      for (int i = 0; i < S; i++) m_pipe.push_back(1'b1);
      m_hist.delete();
      m_level = 0; m_press = 0; m_rel = 0; m_en = 0;
    end else begin
      sk = ~m_pipe[0];
      m_hist.push_back(sk);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      flip = (m_hist.size() >= D);
      for (int i = 0; i < m_hist.size(); i++) if (m_hist[i] == m_level) flip = 1'b0;
      m_press = 0; m_rel = 0;
      if (flip) begin
        m_level = sk; m_press = sk; m_rel = ~sk;
        if (sk) m_en = ~m_en;
        m_hist.delete();
      end
      void'(m_pipe.pop_front());
      m_pipe.push_back(k);
    end
    h_r.push_back(r);
    h_k.push_back(k);
    if (h_r.size() > 8) begin void'(h_r.pop_front()); void'(h_k.pop_front()); end
    ok = 1'b1;
    for (int b = 0; b <= S1; b++) if (!hist_r(b)) ok = 1'b0;
    n_level = ok ? ~hist_k(S1) : 1'b0;
    n_press = r & n_level & ~n_prev;
    n_rel   = r & ~n_level & n_prev;
    if (!r) n_en = 1'b0;
    else if (n_press) n_en = ~n_en;
    n_prev = n_level;
    if (!r) n_on = 1'b1;
  endtask

  task automatic step(input logic r, input logic k);
    @(negedge clk);
    rstn = r;
    key_n = k;
    @(posedge clk);
    model_edge(r, k);
    #1;
    if (n_on) check("dbc1_model", {level1, press1, rel1, en1}, {n_level, n_press, n_rel, n_en});
  endtask

  typedef struct {
    logic       rstn;
    logic       key_n;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic k, input logic [3:0] e);
    vec_t v;
    v.rstn = r; v.key_n = k; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int found, press_cnt, seg_left;
    logic seg_val, r;
    for (int i = 0; i < S; i++) m_pipe.push_back(1'b1);

    add(0, 0, 4'b0000); add(0, 1, 4'b0000); add(0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) add(1, 1, 4'b0000);
    // Bounce: 3 low, 1 high, 3 low, then high.
    for (int i = 0; i < 3; i++) add(1, 0, 4'b0000);
    add(1, 1, 4'b0000);
    for (int i = 0; i < 3; i++) add(1, 0, 4'b0000);
    for (int i = 0; i < 5; i++) add(1, 1, 4'b0000);
    // First press / release.
    for (int i = 0; i < 5; i++) add(1, 0, 4'b0000);
    add(1, 0, 4'b1101);
    for (int i = 0; i < 3; i++) add(1, 0, 4'b1001);
    for (int i = 0; i < 5; i++) add(1, 1, 4'b1001);
    add(1, 1, 4'b0011);
    for (int i = 0; i < 2; i++) add(1, 1, 4'b0001);
    // Second press / release.
    for (int i = 0; i < 5; i++) add(1, 0, 4'b0001);
    add(1, 0, 4'b1100);
    for (int i = 0; i < 2; i++) add(1, 0, 4'b1000);
    for (int i = 0; i < 5; i++) add(1, 1, 4'b1000);
    add(1, 1, 4'b0010);
    for (int i = 0; i < 2; i++) add(1, 1, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rstn, vecs[i].key_n);
      check($sformatf("vec%0d", i), {level0, press0, rel0, en0}, vecs[i].exp);
      if (i == 3) check("cnt_after_reset", {3'b000, dut.cnt_q == '0}, 4'b0001);
    end

    // Reset at debounce count 2 with key held; press counted from rstn release.
    for (int i = 0; i < 4; i++) begin
      step(1, 0);
      check($sformatf("mid_pre%0d", i), {level0, press0, rel0, en0}, 4'b0000);
    end
    step(0, 0);
    check("mid_reset", {level0, press0, rel0, en0}, 4'b0000);
    found = -1;
    press_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      if (press0) begin
        press_cnt++;
        if (found < 0) begin
          found = i;
          check("mid_press_state", {level0, press0, rel0, en0}, 4'b1101);
        end
      end
    end
    check("mid_press_edge", 4'(found + 1), 4'(6));
    check("mid_press_count", 4'(press_cnt), 4'(1));

    // Randomized key traffic with occasional resets.
    step(0, 1);
    step(0, 1);
    seg_left = 0;
    seg_val = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (seg_left == 0) begin
        seg_val = 1'($urandom_range(0, 1));
        seg_left = $urandom_range(1, 9);
      end
      r = ($urandom_range(0, 149) != 0);
      step(r, seg_val);
      seg_left--;
      check($sformatf("rand%0d", c), {level0, press0, rel0, en0}, {m_level, m_press, m_rel, m_en});
      if (press0 && rel0) check("rand_strobe_overlap", {2'b00, press0, rel0}, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream conditioning stage for the LED blinker top level. Takes a raw active-low board pushbutton and produces a clean debounced level, single-cycle press/release strobes and a toggled enable.
- blink_en drives the enable input of the blinker core, so each clean key press starts or stops LEDG blinking.
- Runs entirely in the system1000 domain.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the input synchroniser; must be >= 2.
- DEBOUNCE_CYCLES, 50000, number of consecutive synchronised samples that must differ from the current stable level before that level flips; must be >= 1.
- CNT_W, clog2(DEBOUNCE_CYCLES+1), width of the debounce counter; derived, never overridden.

Ports:
- system1000  input  1  clock; all logic is on the rising edge.
- system1000_rstn  input  1  reset, synchronous, active-low.
- key_n  input  1  raw pushbutton, asynchronous; 0 = pressed.
- key_level  output  1  debounced state; 1 = pressed.
- key_press  output  1  one-cycle strobe when key_level goes 0->1.
- key_release  output  1  one-cycle strobe when key_level goes 1->0.
- blink_en  output  1  toggles on every key_press; feeds the blinker enable.

Behaviour:
- Reset: sampled only on a rising edge with system1000_rstn=0.
  - Synchroniser flops load 1 (released).
  - Counter loads 0.
  - key_level, key_press, key_release and blink_en all load 0.
  - Reset asserted mid-debounce discards the partial count. No strobe is generated by reset itself.
- Synchroniser: key_n passes through SYNC_STAGES flops. sync_key is the inverted output of the last flop (1 = pressed).
- Debounce counter: evaluated every edge after the synchroniser.
  - sync_key == key_level: counter <= 0.
  - sync_key != key_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync_key != key_level and counter == DEBOUNCE_CYCLES-1: key_level <= sync_key and counter <= 0 on the same edge.
- Glitch rejection: any single sample equal to key_level restarts the count from 0. A bounce shorter than DEBOUNCE_CYCLES samples never changes key_level.
- Strobes:
  - key_press and key_release are registered and assert on the same edge key_level changes. Each is high for exactly one cycle.
  - They are never high together.
  - Back-to-back flips are at least DEBOUNCE_CYCLES cycles apart, so strobes are at least DEBOUNCE_CYCLES cycles apart.
- blink_en: inverts on the edge where key_press asserts. It is unaffected by release.
- Latency:
  - A clean step on key_n first captured at rising edge 0 changes key_level at edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - That is the (SYNC_STAGES+DEBOUNCE_CYCLES)-th sampling edge.
- DEBOUNCE_CYCLES=1: key_level follows sync_key with one extra cycle of register delay; the counter is never incremented.
- Key held through reset deassertion: treated as a fresh press. key_level and key_press assert after the normal latency, measured from the first edge with rstn=1.
- No combinational path from key_n to any output. All outputs come straight from flops.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold rstn=0 for 3 edges with key_n toggling -> all outputs 0 throughout and on the first cycle after release; counter 0.
- Clean press: key_n 1->0 first sampled at edge 0, held low -> key_level=1 and key_press=1 after edge 5; key_press=0 after edge 6; blink_en=1 from edge 5.
- Bounce rejection: key_n low for 3 edges, high for 1, low for 3, then high -> key_level stays 0 and no strobe ever asserts.
- Clean release after the press: key_n 0->1 held -> key_release=1 for one cycle exactly 6 edges after the first high sample; key_level=0; blink_en remains 1.
- Second full press/release cycle -> blink_en returns to 0 on the second key_press; strobes one cycle each and never simultaneous.
- Reset mid-debounce: rstn=0 for 1 edge at count 2 during a press, key still held -> no strobe during reset; key_press asserts 6 edges after rstn returns to 1.
